// File: rtl/ef_gpio8_pulse_out_pkg.sv
// Shared definitions for the 8-pin GPIO pulse output block.
// The baseline source priority is defined once here and used by every pin.
package ef_gpio8_pulse_out_pkg;

  localparam int CNT_W_DEF = 16;

  // Baseline update sources, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    SRC_WE   = 3'd0,
    SRC_CLR  = 3'd1,
    SRC_SET  = 3'd2,
    SRC_TGL  = 3'd3,
    SRC_HOLD = 3'd4
  } base_src_e;

  function automatic base_src_e base_src(input logic we, input logic clr,
                                         input logic set, input logic tgl);
    if (we)       return SRC_WE;
    else if (clr) return SRC_CLR;
    else if (set) return SRC_SET;
    else if (tgl) return SRC_TGL;
    else          return SRC_HOLD;
  endfunction

endpackage

// File: rtl/ef_gpio8_pin_pulser.sv
// One GPIO pin: baseline level, retriggerable timed pulse and registered output bit.
module ef_gpio8_pin_pulser
  import ef_gpio8_pulse_out_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bus_out,
  input  logic             bus_we,
  input  logic             set_mask,
  input  logic             clr_mask,
  input  logic             tgl_mask,
  input  logic             pulse_start,
  input  logic [CNT_W-1:0] pulse_len,
  output logic             io_out,
  output logic             pulse_busy,
  output logic             pulse_done
);

  localparam logic [CNT_W-1:0] L_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_base;
  logic             r_pol;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_out;

  logic             w_base_next;
  logic             w_pol_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_busy_next;
  logic             w_done_next;
  logic             w_out_next;
  logic [CNT_W-1:0] w_len_eff;

  always_comb begin
    w_base_next = r_base;
    case (base_src(bus_we, clr_mask, set_mask, tgl_mask))
      SRC_WE:  w_base_next = bus_out;
      SRC_CLR: w_base_next = 1'b0;
      SRC_SET: w_base_next = 1'b1;
      SRC_TGL: w_base_next = ~r_base;
      default: w_base_next = r_base;
    endcase

    w_len_eff   = (pulse_len == '0) ? L_ONE : pulse_len;
    w_pol_next  = r_pol;
    w_cnt_next  = r_cnt;
    w_busy_next = r_busy;
    w_done_next = 1'b0;

    // A start on the final pulse cycle wins, so a retrigger never emits done.
    if (pulse_start) begin
      w_pol_next  = ~w_base_next;
      w_cnt_next  = w_len_eff;
      w_busy_next = 1'b1;
    end else if (r_busy) begin
      if (r_cnt == L_ONE) begin
        w_busy_next = 1'b0;
        w_cnt_next  = '0;
        w_done_next = 1'b1;
      end else begin
        w_cnt_next = r_cnt - L_ONE;
      end
    end

    w_out_next = w_busy_next ? w_pol_next : w_base_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base <= 1'b0;
      r_pol  <= 1'b0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_out  <= 1'b0;
    end else begin
      r_base <= w_base_next;
      r_pol  <= w_pol_next;
      r_cnt  <= w_cnt_next;
      r_busy <= w_busy_next;
      r_done <= w_done_next;
      r_out  <= w_out_next;
    end
  end

  assign io_out     = r_out;
  assign pulse_busy = r_busy;
  assign pulse_done = r_done;

endmodule

// File: rtl/ef_gpio8_pulse_out.sv
// 8-pin GPIO output block: per-pin baseline and timed pulses, registered io_out/io_oe.
module ef_gpio8_pulse_out
  import ef_gpio8_pulse_out_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       bus_out,
  input  logic             bus_we,
  input  logic [7:0]       set_mask,
  input  logic [7:0]       clr_mask,
  input  logic [7:0]       tgl_mask,
  input  logic [7:0]       pulse_start,
  input  logic [CNT_W-1:0] pulse_len,
  input  logic [7:0]       bus_oe,
  output logic [7:0]       io_out,
  output logic [7:0]       io_oe,
  output logic [7:0]       pulse_busy,
  output logic [7:0]       pulse_done
);

  logic [7:0] r_oe;

  // Scalar ports split across the array; bus_we and pulse_len are shared by all pins.
  ef_gpio8_pin_pulser #(.CNT_W(CNT_W)) u_pin [7:0] (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_out    (bus_out),
    .bus_we     (bus_we),
    .set_mask   (set_mask),
    .clr_mask   (clr_mask),
    .tgl_mask   (tgl_mask),
    .pulse_start(pulse_start),
    .pulse_len  (pulse_len),
    .io_out     (io_out),
    .pulse_busy (pulse_busy),
    .pulse_done (pulse_done)
  );

  // Same one-cycle latency as io_out so enable and level change together at the pad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oe <= 8'h00;
    end else begin
      r_oe <= bus_oe;
    end
  end

  assign io_oe = r_oe;

endmodule

// File: tb/tb_ef_gpio8_pulse_out.sv
// Scoreboard bench for ef_gpio8_pulse_out: stimulus queues expected outputs per edge, a monitor checks them.
module tb_ef_gpio8_pulse_out;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  bus_out, set_mask, clr_mask, tgl_mask, pulse_start, bus_oe;
  logic        bus_we;
  logic [15:0] pulse_len;
  logic [7:0]  io_out, io_oe, pulse_busy, pulse_done;

  typedef struct {
    int         cyc;
    logic [7:0] out;
    logic [7:0] oe;
    logic [7:0] busy;
    logic [7:0] done;
    string      nm;
  } exp_t;

  exp_t       q[$];
  exp_t       e_mon;
  int         cyc_cnt = 0;
  int         checks  = 0;
  int         errors  = 0;
  logic [7:0] oe_exp  = 8'h00;

  ef_gpio8_pulse_out #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_out    (bus_out),
    .bus_we     (bus_we),
    .set_mask   (set_mask),
    .clr_mask   (clr_mask),
    .tgl_mask   (tgl_mask),
    .pulse_start(pulse_start),
    .pulse_len  (pulse_len),
    .bus_oe     (bus_oe),
    .io_out     (io_out),
    .io_oe      (io_oe),
    .pulse_busy (pulse_busy),
    .pulse_done (pulse_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: every entry due at or before this cycle is popped and compared.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      e_mon = q.pop_front();
      checks++;
      if (e_mon.cyc != cyc_cnt || io_out !== e_mon.out || io_oe !== e_mon.oe ||
          pulse_busy !== e_mon.busy || pulse_done !== e_mon.done) begin
        errors++;
        $display("FAIL %s cyc %0d: got out=%h oe=%h busy=%h done=%h, want out=%h oe=%h busy=%h done=%h",
                 e_mon.nm, cyc_cnt, io_out, io_oe, pulse_busy, pulse_done,
                 e_mon.out, e_mon.oe, e_mon.busy, e_mon.done);
      end
    end
  end

  // Push expectation for the next edge, clock once, then clear one-cycle strobes.
  task automatic cyc(input string nm, input logic [7:0] eo, input logic [7:0] eb,
                     input logic [7:0] ed);
    exp_t e;
    e.cyc  = cyc_cnt + 1;
    e.out  = eo;
    e.oe   = oe_exp;
    e.busy = eb;
    e.done = ed;
    e.nm   = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
    bus_we      = 1'b0;
    set_mask    = 8'h00;
    clr_mask    = 8'h00;
    tgl_mask    = 8'h00;
    pulse_start = 8'h00;
  endtask

  task automatic chk_now(input string nm);
    checks++;
    if (io_out !== 8'h00 || io_oe !== 8'h00 || pulse_busy !== 8'h00 || pulse_done !== 8'h00) begin
      errors++;
      $display("FAIL %s: got out=%h oe=%h busy=%h done=%h, want all 00",
               nm, io_out, io_oe, pulse_busy, pulse_done);
    end
  endtask

  initial begin
    rst_n = 1'b0; bus_out = 8'h00; bus_we = 1'b0; set_mask = 8'h00; clr_mask = 8'h00;
    tgl_mask = 8'h00; pulse_start = 8'h00; pulse_len = 16'd0; bus_oe = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_now("reset_state");
    rst_n = 1'b1;
    cyc("idle0", 8'h00, 8'h00, 8'h00);
    cyc("idle1", 8'h00, 8'h00, 8'h00);

    // Baseline sequence plus output enables
    bus_out = 8'hA5; bus_we = 1'b1; bus_oe = 8'h3C; oe_exp = 8'h3C;
    cyc("base_we_A5", 8'hA5, 8'h00, 8'h00);
    set_mask = 8'h02;  cyc("base_set_02", 8'hA7, 8'h00, 8'h00);
    clr_mask = 8'h80;  cyc("base_clr_80", 8'h27, 8'h00, 8'h00);
    tgl_mask = 8'h0F;  cyc("base_tgl_0F", 8'h28, 8'h00, 8'h00);

    // Same-cycle priority
    bus_out = 8'h00; bus_we = 1'b1; cyc("prio_zero", 8'h00, 8'h00, 8'h00);
    set_mask = 8'h01; clr_mask = 8'h01; tgl_mask = 8'h01;
    cyc("prio_clr_wins", 8'h00, 8'h00, 8'h00);
    set_mask = 8'h01; clr_mask = 8'h01; tgl_mask = 8'h01; bus_out = 8'h01; bus_we = 1'b1;
    cyc("prio_we_wins", 8'h01, 8'h00, 8'h00);
    bus_out = 8'h00; bus_we = 1'b1; cyc("prio_back0", 8'h00, 8'h00, 8'h00);

    // High-going 5-cycle pulse on pin 3
    pulse_len = 16'd5; pulse_start = 8'h08;
    for (int i = 0; i < 5; i++) cyc("pulse5_hi", 8'h08, 8'h08, 8'h00);
    cyc("pulse5_done", 8'h00, 8'h00, 8'h08);
    cyc("pulse5_idle", 8'h00, 8'h00, 8'h00);

    // Low-going pulse from base FF, with baseline edits while busy
    bus_out = 8'hFF; bus_we = 1'b1; cyc("base_FF", 8'hFF, 8'h00, 8'h00);
    pulse_start = 8'h08;  cyc("lo_p1", 8'hF7, 8'h08, 8'h00);
    cyc("lo_p2", 8'hF7, 8'h08, 8'h00);
    tgl_mask = 8'h01;     cyc("lo_p3_tgl", 8'hF6, 8'h08, 8'h00);
    clr_mask = 8'h08;     cyc("lo_p4_clr", 8'hF6, 8'h08, 8'h00);
    cyc("lo_p5", 8'hF6, 8'h08, 8'h00);
    cyc("lo_done", 8'hF6, 8'h00, 8'h08);
    cyc("lo_idle", 8'hF6, 8'h00, 8'h00);

    // pulse_len = 0 acts as a 1-cycle pulse
    pulse_len = 16'd0; pulse_start = 8'h01;
    cyc("len0_p", 8'hF7, 8'h01, 8'h00);
    cyc("len0_done", 8'hF6, 8'h00, 8'h01);
    cyc("len0_idle", 8'hF6, 8'h00, 8'h00);

    // Retrigger on the final cycle of a 4-cycle pulse
    bus_out = 8'h00; bus_we = 1'b1; cyc("rt_base0", 8'h00, 8'h00, 8'h00);
    pulse_len = 16'd4; pulse_start = 8'h04;
    for (int i = 0; i < 4; i++) cyc("rt_first", 8'h04, 8'h04, 8'h00);
    pulse_len = 16'd3; pulse_start = 8'h04;
    for (int i = 0; i < 3; i++) cyc("rt_second", 8'h04, 8'h04, 8'h00);
    cyc("rt_done", 8'h00, 8'h00, 8'h04);
    cyc("rt_idle", 8'h00, 8'h00, 8'h00);

    // Simultaneous starts on pins 7 and 0
    pulse_len = 16'd2; pulse_start = 8'h81;
    cyc("multi_p1", 8'h81, 8'h81, 8'h00);
    cyc("multi_p2", 8'h81, 8'h81, 8'h00);
    cyc("multi_done", 8'h00, 8'h00, 8'h81);

    // Asynchronous reset in the middle of a pulse
    pulse_len = 16'd10; pulse_start = 8'h10;
    cyc("rst_p1", 8'h10, 8'h10, 8'h00);
    cyc("rst_p2", 8'h10, 8'h10, 8'h00);
    #6;
    rst_n = 1'b0;
    #1;
    chk_now("async_reset");
    @(posedge clk);
    #1;
    chk_now("reset_held");
    rst_n = 1'b1;
    cyc("post_rst", 8'h00, 8'h00, 8'h00);

    // Maximum length pulse
    pulse_len = 16'hFFFF; pulse_start = 8'h01;
    for (int i = 0; i < 65535; i++) cyc("long_busy", 8'h01, 8'h01, 8'h00);
    cyc("long_done", 8'h00, 8'h00, 8'h01);
    cyc("long_idle", 8'h00, 8'h00, 8'h00);

    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
